boruss_fetch: RTL and testbench

Instruction fetch stage of the Boruss CPU. Drives the 8-bit address of the program ROM (combinational read, data valid in the same cycle), assembles 1- or 2-byte instructions, and presents them to the execute stage through a valid/ready handshake. Execute redirects the fetch PC on taken branches.

---
 rtl/boruss_fetch.sv | 136 +++++++++++++
 tb/tb_boruss_fetch.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/boruss_fetch.sv
// boruss_fetch -- instruction fetch stage of the Boruss CPU.
//
// Walks the program ROM one byte per cycle, assembles 1- or 2-byte
// instructions and holds each one on a valid/ready handshake until execute
// accepts it. Execute can redirect the fetch PC at any time; a redirect
// discards whatever is partially fetched or being held.
//
// Two-byte encodings: opcode 4'b0000 with src 2'b01 (LOAD immediate), and
// every opcode 4'b1xxx (jump class). Everything else is a single byte.
//
// Optional feature macro: BORUSS_FETCH_JMP_FOLD_EN
//   When defined, an unconditional JMP (opcode 4'b1000) is resolved here:
//   its target byte is loaded straight into the PC and the JMP is never
//   presented to execute. When undefined, JMP is presented like any other
//   2-byte instruction and execute must redirect.
//
// Parameters:
//   RESET_PC        PC loaded on reset (default 8'h00)
// Ports:
//   clk             clock, rising edge
//   rst_n           asynchronous active-low reset
//   rom_addr        ROM address, driven only from the registered PC
//   rom_data        ROM read data for rom_addr, same cycle
//   instr_valid     a complete instruction is presented
//   instr_ready     execute accepts when instr_valid && instr_ready
//   instr_op        first instruction byte {opcode, dest, src}
//   instr_imm       second byte, 8'h00 for 1-byte instructions
//   instr_len2      1 = 2-byte instruction
//   instr_pc        address of instr_op
//   redirect_valid  load the PC from redirect_addr (highest priority)
//   redirect_addr   new fetch address

module boruss_fetch #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [7:0] instr_op,
  output logic [7:0] instr_imm,
  output logic       instr_len2,
  output logic [7:0] instr_pc,
  input  logic       redirect_valid,
  input  logic [7:0] redirect_addr
);

  typedef enum logic [1:0] {
    F_OP  = 2'd0,
    F_IMM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] pc;

  // LOAD immediate (0000_xx_01) or any jump-class opcode carries a second byte.
  function automatic logic is_len2(input logic [7:0] op);
    return ((op[7:4] == 4'b0000) && (op[1:0] == 2'b01)) || op[7];
  endfunction

  // The ROM address never looks at instr_ready; it is the registered PC only.
  assign rom_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= F_OP;
      pc          <= RESET_PC;
      instr_valid <= 1'b0;
      instr_op    <= 8'h00;
      instr_imm   <= 8'h00;
      instr_len2  <= 1'b0;
      instr_pc    <= 8'h00;
    end else if (redirect_valid) begin
      // Redirect wins over everything. A same-cycle accept has already been
      // seen by execute on this edge, so dropping valid is all that's needed.
      pc          <= redirect_addr;
      state       <= F_OP;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        // First byte: capture opcode and its address, decide on length.
        F_OP: begin
          instr_op <= rom_data;
          instr_pc <= pc;
          pc       <= pc + 8'd1;
          if (is_len2(rom_data)) begin
            instr_len2 <= 1'b1;
            state      <= F_IMM;
          end else begin
            instr_len2  <= 1'b0;
            instr_imm   <= 8'h00;
            instr_valid <= 1'b1;
            state       <= HOLD;
          end
        end

        // Second byte: immediate (or folded JMP target).
        F_IMM: begin
`ifdef BORUSS_FETCH_JMP_FOLD_EN
          if (instr_op[7:4] == 4'b1000) begin
            pc    <= rom_data;
            state <= F_OP;
          end else begin
            instr_imm   <= rom_data;
            pc          <= pc + 8'd1;
            instr_valid <= 1'b1;
            state       <= HOLD;
          end
`else
          instr_imm   <= rom_data;
          pc          <= pc + 8'd1;
          instr_valid <= 1'b1;
          state       <= HOLD;
`endif
        end

        // Present and wait; no fetch overlaps with the hold.
        HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            state       <= F_OP;
          end
        end

        default: begin
          instr_valid <= 1'b0;
          state       <= F_OP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boruss_fetch.sv
// Directed bench for boruss_fetch: a behavioural ROM array feeds rom_data
// combinationally from rom_addr; outputs are sampled on the falling edge and
// inputs are changed right after sampling.
module tb_boruss_fetch;

  logic       clk;
  logic       rst_n;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr_op;
  logic [7:0] instr_imm;
  logic       instr_len2;
  logic [7:0] instr_pc;
  logic       redirect_valid;
  logic [7:0] redirect_addr;

  logic [7:0] mem [256];

  int n_chk;
  int n_err;

  boruss_fetch #(.RESET_PC(8'h00)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_op       (instr_op),
    .instr_imm      (instr_imm),
    .instr_len2     (instr_len2),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr)
  );

  assign rom_data = mem[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_instr(input string tag, input logic [7:0] op, input logic [7:0] imm,
                           input logic len2, input logic [7:0] pc);
    chk({tag, ".valid"}, {7'd0, instr_valid}, 8'h01);
    chk({tag, ".op"},    instr_op,  op);
    chk({tag, ".imm"},   instr_imm, imm);
    chk({tag, ".len2"},  {7'd0, instr_len2}, {7'd0, len2});
    chk({tag, ".pc"},    instr_pc,  pc);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h20;
    mem[8'h00] = 8'h01;  // LOAD imm
    mem[8'h01] = 8'h01;
    mem[8'h02] = 8'h60;  // 1-byte
    mem[8'h03] = 8'h20;
    mem[8'h04] = 8'h01;  // LOAD imm, interrupted by redirect
    mem[8'h05] = 8'h77;
    mem[8'h40] = 8'h30;
    mem[8'hFF] = 8'h01;
    mem[8'h19] = 8'h80;  // JMP 0x00
    mem[8'h1A] = 8'h00;

    rst_n = 1'b0;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr = 8'h00;

    // Reset values
    #3;
    chk("rst.valid", {7'd0, instr_valid}, 8'h00);
    chk("rst.op",    instr_op,  8'h00);
    chk("rst.imm",   instr_imm, 8'h00);
    chk("rst.len2",  {7'd0, instr_len2}, 8'h00);
    chk("rst.pc",    instr_pc,  8'h00);
    chk("rst.addr",  rom_addr,  8'h00);

    @(negedge clk); rst_n = 1'b1;
    // LOAD imm at 0x00: two edges to valid
    @(negedge clk);
    chk("ld.mid_valid", {7'd0, instr_valid}, 8'h00);
    chk("ld.mid_addr",  rom_addr, 8'h01);
    @(negedge clk);
    chk_instr("ld", 8'h01, 8'h01, 1'b1, 8'h00);
    chk("ld.addr", rom_addr, 8'h02);

    // Accept; ready stays high one more cycle while valid is low (no effect)
    instr_ready = 1'b1;
    @(negedge clk);
    chk("acc1.valid", {7'd0, instr_valid}, 8'h00);
    chk("acc1.addr",  rom_addr, 8'h02);
    @(negedge clk);
    instr_ready = 1'b0;
    chk_instr("b60", 8'h60, 8'h00, 1'b0, 8'h02);

    // Held for 5 cycles with ready low
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold.valid", {7'd0, instr_valid}, 8'h01);
      chk("hold.op",    instr_op, 8'h60);
      chk("hold.pc",    instr_pc, 8'h02);
      chk("hold.addr",  rom_addr, 8'h03);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    chk("acc2.valid", {7'd0, instr_valid}, 8'h00);
    @(negedge clk);
    chk_instr("b03", 8'h20, 8'h00, 1'b0, 8'h03);

    // Redirect during F_IMM of the LOAD at 0x04
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    chk("f4.addr", rom_addr, 8'h04);
    @(negedge clk);
    chk("f4.imm_addr",  rom_addr, 8'h05);
    chk("f4.imm_valid", {7'd0, instr_valid}, 8'h00);
    redirect_valid = 1'b1;
    redirect_addr  = 8'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("rd40.valid", {7'd0, instr_valid}, 8'h00);
    chk("rd40.addr",  rom_addr, 8'h40);
    @(negedge clk);
    chk_instr("rd40", 8'h30, 8'h00, 1'b0, 8'h40);

    // Accept and redirect together to 0xFF; immediate wraps to 0x00
    mem[8'h00] = 8'hA5;
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr  = 8'hFF;
    @(negedge clk);
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    chk("rdff.valid", {7'd0, instr_valid}, 8'h00);
    chk("rdff.addr",  rom_addr, 8'hFF);
    @(negedge clk);
    chk("wrap.imm_addr", rom_addr, 8'h00);
    @(negedge clk);
    chk_instr("wrap", 8'h01, 8'hA5, 1'b1, 8'hFF);
    chk("wrap.addr", rom_addr, 8'h01);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_instr("after_wrap", 8'h01, 8'h60, 1'b1, 8'h01);

    // JMP at 0x19 to 0x00
    mem[8'h00] = 8'h20;
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr  = 8'h19;
    @(negedge clk);
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    chk("jmp.addr", rom_addr, 8'h19);
    @(negedge clk);
    chk("jmp.f_imm_valid", {7'd0, instr_valid}, 8'h00);
    chk("jmp.f_imm_addr",  rom_addr, 8'h1A);
`ifdef BORUSS_FETCH_JMP_FOLD_EN
    @(negedge clk);
    chk("fold.valid", {7'd0, instr_valid}, 8'h00);
    chk("fold.addr",  rom_addr, 8'h00);
    @(negedge clk);
    chk_instr("fold", 8'h20, 8'h00, 1'b0, 8'h00);
`else
    @(negedge clk);
    chk_instr("jmp", 8'h80, 8'h00, 1'b1, 8'h19);
    chk("jmp.addr_after", rom_addr, 8'h1B);
`endif

    // Asynchronous reset while holding, away from any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.valid", {7'd0, instr_valid}, 8'h00);
    chk("arst.op",    instr_op,  8'h00);
    chk("arst.imm",   instr_imm, 8'h00);
    chk("arst.len2",  {7'd0, instr_len2}, 8'h00);
    chk("arst.pc",    instr_pc,  8'h00);
    chk("arst.addr",  rom_addr,  8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_instr("restart", 8'h20, 8'h00, 1'b0, 8'h00);
    chk("restart.addr", rom_addr, 8'h01);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
